// File: rtl/dsi_tx_arbiter.sv
// DSI transmit arbiter: picks a command or video packet source, streams the
// packet words to the lane interface, and enforces LP/HS mode windows and an
// inter-packet guard time.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | arbitration disabled or DSI clock lane not running
// ARB       | waiting for a source to request; grant decided here
// SETUP     | one cycle with lpm_en driven before the first word
// XFER      | words pass from the owner straight to the lane interface
// HOLD      | one cycle after the last word with lpm_en still driven
// WAIT_DONE | waiting for the lanes to stop transmitting
// GUARD     | enforced idle gap before the next arbitration
module dsi_tx_arbiter #(
    parameter int GUARD_CYCLES = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clock_ready,
    input  logic [31:0] vid_data,
    input  logic [3:0]  vid_strb,
    input  logic        vid_valid,
    input  logic        vid_last,
    output logic        vid_ready,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_strb,
    input  logic        cmd_valid,
    input  logic        cmd_last,
    input  logic        cmd_lp,
    output logic        cmd_ready,
    output logic [31:0] iface_write_data,
    output logic [3:0]  iface_write_strb,
    output logic        iface_write_rqst,
    output logic        iface_last_word,
    output logic        iface_lpm_en,
    input  logic        iface_data_rqst,
    input  logic        lines_active,
    output logic        busy,
    output logic        grant_cmd,
    output logic        err_underflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_WAIT_DONE,
        S_GUARD
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    // GUARD_CYCLES of 0 still spends one cycle in GUARD.
    localparam logic [7:0] GUARD_LOAD = (GUARD_CYCLES == 0) ? 8'd0 : 8'(GUARD_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_starve_cnt;
    logic [7:0]  r_guard_cnt;
    logic        r_owner_cmd;
    logic        r_mode;
    logic        r_err;

    logic        w_run;
    logic        w_grant_any;
    logic        w_grant_vid;
    logic        w_grant;
    logic        w_own_valid;
    logic        w_own_last;

    assign w_run       = enable & clock_ready;
    assign w_grant_any = vid_valid | cmd_valid;
    // Command wins unless video has waited through STARVE_LIMIT command grants.
    assign w_grant_vid = vid_valid & (~cmd_valid | (r_starve_cnt == STARVE_MAX));
    assign w_grant     = (r_state == S_ARB) & w_run & w_grant_any;
    assign w_own_valid = r_owner_cmd ? cmd_valid : vid_valid;
    assign w_own_last  = r_owner_cmd ? cmd_last : vid_last;

    assign busy          = (r_state != S_IDLE) && (r_state != S_ARB);
    assign grant_cmd     = r_owner_cmd;
    assign err_underflow = r_err;

    // Next-state decode and lane-interface muxing.
    always_comb begin
        w_state_nxt      = r_state;
        iface_write_data = '0;
        iface_write_strb = '0;
        iface_write_rqst = 1'b0;
        iface_last_word  = 1'b0;
        iface_lpm_en     = 1'b0;
        vid_ready        = 1'b0;
        cmd_ready        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_run) w_state_nxt = S_ARB;
            end
            S_ARB: begin
                if (!w_run)          w_state_nxt = S_IDLE;
                else if (w_grant_any) w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                iface_lpm_en = r_mode;
                w_state_nxt  = S_XFER;
            end
            S_XFER: begin
                iface_lpm_en     = r_mode;
                iface_write_data = r_owner_cmd ? cmd_data : vid_data;
                iface_write_strb = r_owner_cmd ? cmd_strb : vid_strb;
                iface_last_word  = w_own_last;
                iface_write_rqst = w_own_valid;
                cmd_ready        = r_owner_cmd & iface_data_rqst;
                vid_ready        = ~r_owner_cmd & iface_data_rqst;
                if (w_own_valid && w_own_last && iface_data_rqst) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                iface_lpm_en = r_mode;
                w_state_nxt  = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!lines_active) w_state_nxt = S_GUARD;
            end
            S_GUARD: begin
                if (r_guard_cnt == 8'd0) w_state_nxt = w_run ? S_ARB : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, grant bookkeeping, guard timer and sticky underflow flag.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_guard_cnt  <= '0;
            r_owner_cmd  <= 1'b0;
            r_mode       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner_cmd <= ~w_grant_vid;
                r_mode      <= w_grant_vid ? 1'b0 : cmd_lp;
                if (w_grant_vid)
                    r_starve_cnt <= '0;
                else if (vid_valid && (r_starve_cnt != STARVE_MAX))
                    r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            if ((r_state == S_WAIT_DONE) && !lines_active)
                r_guard_cnt <= GUARD_LOAD;
            else if ((r_state == S_GUARD) && (r_guard_cnt != 8'd0))
                r_guard_cnt <= r_guard_cnt - 8'd1;
            if ((r_state == S_XFER) && !w_own_valid)
                r_err <= 1'b1;
        end
    end

endmodule

// File: doc/dsi_tx_arbiter.md
DSI_TX_ARBITER -- requirements
Module: dsi_tx_arbiter

Interface
REQ-001 Parameter GUARD_CYCLES, default 4: idle cycles enforced between consecutive packets after lanes go inactive; legal range 0-255.
REQ-002 Parameter STARVE_LIMIT, default 3: consecutive command-packet grants allowed while video is pending; legal range 1-15.
REQ-003 clk_sys  in  1  system clock; all logic is in this single clock domain.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 enable  in  1  arbitration enable.
REQ-006 clock_ready  in  1  DSI clock lane running.
REQ-007 vid_data  in  32  video word; vid_strb  in  4  byte strobes; vid_valid  in  1; vid_last  in  1  final word of packet.
REQ-008 vid_ready  out  1  video word consumed this cycle.
REQ-009 cmd_data  in  32; cmd_strb  in  4; cmd_valid  in  1; cmd_last  in  1; cmd_lp  in  1  packet requests LP mode (1) or HS mode (0).
REQ-010 cmd_ready  out  1  command word consumed this cycle.
REQ-011 iface_write_data  out  32; iface_write_strb  out  4; iface_write_rqst  out  1; iface_last_word  out  1; iface_lpm_en  out  1  (0 = HS, 1 = LP).
REQ-012 iface_data_rqst  in  1  lanes consumed current word; lines_active  in  1  lanes still transmitting.
REQ-013 busy  out  1  state not IDLE/ARB; grant_cmd  out  1  current owner is command; err_underflow  out  1  sticky.

Function
REQ-014 FSM states: IDLE, ARB, SETUP, XFER, HOLD, WAIT_DONE, GUARD.
REQ-015 IDLE -> ARB when enable=1 and clock_ready=1; ARB -> IDLE when either is 0.
REQ-016 ARB grants on the cycle any valid is high, then -> SETUP; no grant means stay in ARB.
REQ-017 Priority: command over video.
REQ-018 Starvation exception: if vid_valid=1 and starve_cnt==STARVE_LIMIT, video is granted.
REQ-019 starve_cnt increments on each command grant made while vid_valid=1, clears on a video grant, and saturates at STARVE_LIMIT.
REQ-020 At grant, the registered owner and mode are latched: mode = cmd_lp for a command grant, 0 for a video grant. Both are held until the following ARB.
REQ-021 SETUP lasts exactly 1 cycle. iface_lpm_en equals the latched mode from SETUP through HOLD inclusive, and is 0 in all other states.
REQ-022 In XFER, data/strb/last pass combinationally from the owner.
REQ-023 In XFER, iface_write_rqst equals owner valid; owner ready equals iface_data_rqst; non-owner ready = 0.
REQ-024 Outside XFER: iface_write_rqst = 0, both ready = 0, and data/strb/last = 0.
REQ-025 XFER -> HOLD on the cycle iface_data_rqst=1 while owner last=1.
REQ-026 HOLD lasts 1 cycle with write_rqst=0, so lpm_en is deasserted at least 1 cycle after the last word.
REQ-027 WAIT_DONE -> GUARD when lines_active=0.
REQ-028 GUARD counts GUARD_CYCLES cycles (GUARD_CYCLES=0 means a 1-cycle pass-through), then -> ARB.
REQ-029 Packets are never preempted.
REQ-030 enable or clock_ready dropping mid-packet: the current packet completes through GUARD, then the FSM goes to IDLE instead of ARB.
REQ-031 Owner valid=0 in XFER before its last word: err_underflow sets and stays set until reset, and the FSM stays in XFER.
REQ-032 iface_data_rqst=1 while write_rqst=0 is ignored.
REQ-033 Simultaneous vid_valid and cmd_valid in ARB: REQ-017 and REQ-018 decide the grant, evaluated in one cycle.
REQ-034 Source protocol: a source holds data stable while valid=1 and ready=0.

Reset
REQ-035 With rst_n=0 at a clk_sys edge: state = IDLE, and starve_cnt, guard counter, owner, mode and err_underflow = 0.
REQ-036 All outputs are 0 during and immediately after reset.
REQ-037 Reset asserted mid-packet aborts immediately; no packet completion is attempted.

Verification
REQ-038 Single video packet of 3 words, lines_active low 2 cycles after the last word -> lpm_en stays 0, vid_ready pulses 3 times matching data_rqst, busy returns to 0 after 4+2+GUARD_CYCLES cycles.
REQ-039 Command packet with cmd_lp=1 -> lpm_en=1 one cycle before the first write_rqst and still 1 one cycle after the last word, then 0.
REQ-040 Both sources continuously valid, STARVE_LIMIT=3 -> grant order cmd, cmd, cmd, vid, cmd, cmd, cmd, vid.
REQ-041 cmd_valid rises while a video packet is in XFER -> video completes all words before grant_cmd=1.
REQ-042 Owner valid dropped for 2 cycles mid-packet -> write_rqst=0 for those cycles, err_underflow=1 and remains 1, packet then completes.
REQ-043 enable dropped during XFER -> packet completes, FSM reaches IDLE; rst_n=0 mid-XFER -> all outputs 0 on the next cycle.
